freq_step_scheduler: RTL and testbench

// - Sequences a programmable clock-divider tone generator through a table of NUM_STEPS (divisor, dwell) entries.
// - The table is written over a simple config port. A start/stop handshake controls the sweep.
// - Each step drives the shared divider for `dwell` output ticks, then advances to the next step.
// - Sits between the control/CSR logic and the frequency outputs (tick strobe, square wave) that feed LEDs/buzzer.

---
 rtl/freq_step_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_freq_step_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_step_scheduler.sv
// -----------------------------------------------------------------------------
// freq_step_scheduler
//
// Steps a shared clock divider through a table of (divisor, dwell) entries.
// Each entry produces `dwell` output ticks spaced `divisor` clk cycles apart,
// then the scheduler moves to the next entry. It either wraps to entry 0
// (loop_en=1) or finishes with a one-cycle `done` pulse.
//
// Ports
//   clk        system clock, all logic on posedge
//   reset      synchronous, active-high; table contents are retained
//   cfg_we     table write strobe (honoured only while idle)
//   cfg_addr   table entry index
//   cfg_div    divisor for the entry (clk cycles per tick)
//   cfg_dwell  dwell for the entry (ticks per step)
//   start      pulse: begin a sweep at entry 0
//   stop       pulse: abort a sweep
//   loop_en    1 = wrap from the last entry back to entry 0
//   busy       sweep in progress
//   done       one-cycle pulse after a non-looping sweep completes
//   step_idx   index of the current entry
//   tick       one-cycle strobe every `div` cycles while running
//   wave       square wave, toggles on every tick
//   dbg_state  current FSM state (IDLE=0, LOAD=1, RUN=2)
//
// Control handshake: start and stop are single-cycle requests with no ready
// return. start is acted on only while idle. stop is acted on in any busy
// state. When both are high together, stop wins and start is dropped. The
// outcome is visible on busy in the next cycle.
// -----------------------------------------------------------------------------
module freq_step_scheduler #(
  parameter int NUM_STEPS = 8,
  parameter int DIV_W     = 24,
  parameter int DWELL_W   = 8,
  localparam int IDX_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_addr,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  output logic               busy,
  output logic               done,
  output logic [IDX_W-1:0]   step_idx,
  output logic               tick,
  output logic               wave,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t state, state_n;

  logic [DIV_W-1:0]   div_tab   [NUM_STEPS];
  logic [DWELL_W-1:0] dwell_tab [NUM_STEPS];

  logic [DIV_W-1:0]   div_r, div_cnt, div_eff;
  logic [DWELL_W-1:0] dwell_r, dwell_cnt, dwell_eff;
  logic [IDX_W-1:0]   idx_r, idx_n;
  logic               wave_r, done_r;
  logic               tick_c, step_end, last_step, finish;
  logic               addr_ok, cfg_ok;

  // When the index width exactly covers the table, every address is valid.
  if ((2 ** IDX_W) == NUM_STEPS) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_part
    assign addr_ok = ({{(32-IDX_W){1'b0}}, cfg_addr} < NUM_STEPS);
  end

  assign cfg_ok = cfg_we && addr_ok && (state == S_IDLE) && !reset;

  // Table storage has no reset so its contents survive a reset.
  always_ff @(posedge clk) begin
    if (cfg_ok) begin
      div_tab[cfg_addr]   <= cfg_div;
      dwell_tab[cfg_addr] <= cfg_dwell;
    end
  end

  // Sanitised entry values: a divisor below 2 cannot produce a tick/wave,
  // and a zero dwell would never end the step.
  assign div_eff   = (div_tab[idx_r] < DIV_W'(2)) ? DIV_W'(2) : div_tab[idx_r];
  assign dwell_eff = (dwell_tab[idx_r] == '0) ? DWELL_W'(1) : dwell_tab[idx_r];

  assign tick_c    = (state == S_RUN) && (div_cnt == div_r - DIV_W'(1));
  assign step_end  = tick_c && (dwell_cnt == dwell_r - DWELL_W'(1));
  assign last_step = (idx_r == IDX_W'(NUM_STEPS - 1));

  always_comb begin
    state_n = state;
    idx_n   = idx_r;
    finish  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          state_n = S_LOAD;
          idx_n   = '0;
        end
      end
      S_LOAD: begin
        if (stop) begin
          state_n = S_IDLE;
          idx_n   = '0;
        end else begin
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_n = S_IDLE;
          idx_n   = '0;
        end else if (step_end) begin
          if (!last_step) begin
            state_n = S_LOAD;
            idx_n   = idx_r + IDX_W'(1);
          end else if (loop_en) begin
            state_n = S_LOAD;
            idx_n   = '0;
          end else begin
            state_n = S_IDLE;
            idx_n   = '0;
            finish  = 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        idx_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      idx_r     <= '0;
      div_r     <= '0;
      dwell_r   <= '0;
      div_cnt   <= '0;
      dwell_cnt <= '0;
      wave_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state  <= state_n;
      idx_r  <= idx_n;
      done_r <= finish;

      // LOAD restarts the divider phase for the new entry.
      if (state == S_LOAD) begin
        div_r     <= div_eff;
        dwell_r   <= dwell_eff;
        div_cnt   <= '0;
        dwell_cnt <= '0;
      end else if (state == S_RUN) begin
        div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
        if (tick_c) begin
          dwell_cnt <= dwell_cnt + DWELL_W'(1);
        end
      end

      // wave holds across LOAD and is parked low whenever the sweep ends.
      if (state_n == S_IDLE) begin
        wave_r <= 1'b0;
      end else if (tick_c) begin
        wave_r <= ~wave_r;
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = done_r;
  assign step_idx  = idx_r;
  assign tick      = tick_c;
  assign wave      = wave_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_freq_step_scheduler.sv
// -----------------------------------------------------------------------------
// tb_freq_step_scheduler
//
// Reference model: tracks the sweep as "cycles until next tick" and "ticks
// left in this step", reloaded from a table copy. A compare process checks
// all outputs on every cycle after reset. Directed sweeps pin the timing with
// hand-computed offsets from the start cycle T. A randomized phase follows.
// -----------------------------------------------------------------------------
module tb_freq_step_scheduler;

  localparam int N       = 8;
  localparam int DIV_W   = 24;
  localparam int DWELL_W = 8;
  localparam int IDX_W   = 3;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               cfg_we;
  logic [IDX_W-1:0]   cfg_addr;
  logic [DIV_W-1:0]   cfg_div;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               start, stop, loop_en;
  logic               busy, done, tick, wave;
  logic [IDX_W-1:0]   step_idx;
  logic [1:0]         dbg_state;

  freq_step_scheduler #(.NUM_STEPS(N), .DIV_W(DIV_W), .DWELL_W(DWELL_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_div   (cfg_div),
    .cfg_dwell (cfg_dwell),
    .start     (start),
    .stop      (stop),
    .loop_en   (loop_en),
    .busy      (busy),
    .done      (done),
    .step_idx  (step_idx),
    .tick      (tick),
    .wave      (wave),
    .dbg_state (dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural reference model
  // ---------------------------------------------------------------------------
  int m_tdiv   [N];
  int m_tdwell [N];
  bit m_busy, m_load, m_wave, m_done;
  int m_idx, m_div, m_cyc_left, m_ticks_left;
  bit check_en = 1'b0;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  always @(posedge clk) begin : model_p
    bit nd;
    nd = 1'b0;
    if (reset) begin
      m_busy = 0; m_load = 0; m_idx = 0; m_wave = 0; m_done = 0;
      m_cyc_left = 0; m_ticks_left = 0;
      check_en = 1'b1;
    end else begin
      if (!m_busy) begin
        if (cfg_we && (int'(cfg_addr) < N)) begin
          m_tdiv[cfg_addr]   = int'(cfg_div);
          m_tdwell[cfg_addr] = int'(cfg_dwell);
        end
        if (start && !stop) begin
          m_busy = 1; m_load = 1; m_idx = 0;
        end
      end else if (stop) begin
        m_busy = 0; m_load = 0; m_idx = 0; m_wave = 0;
      end else if (m_load) begin
        m_load       = 0;
        m_div        = max2(m_tdiv[m_idx], 2);
        m_cyc_left   = m_div;
        m_ticks_left = max2(m_tdwell[m_idx], 1);
      end else if (m_cyc_left == 1) begin
        m_wave       = ~m_wave;
        m_cyc_left   = m_div;
        m_ticks_left = m_ticks_left - 1;
        if (m_ticks_left == 0) begin
          if (m_idx < N - 1) begin
            m_idx = m_idx + 1; m_load = 1;
          end else if (loop_en) begin
            m_idx = 0; m_load = 1;
          end else begin
            m_busy = 0; m_idx = 0; m_wave = 0; nd = 1'b1;
          end
        end
      end else begin
        m_cyc_left = m_cyc_left - 1;
      end
      m_done = nd;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: every cycle after the first reset edge
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (check_en) begin
      chk("busy",     32'(busy),     32'(m_busy));
      chk("done",     32'(done),     32'(m_done));
      chk("step_idx", 32'(step_idx), 32'(m_idx));
      chk("tick",     32'(tick),     32'(m_busy && !m_load && m_cyc_left == 1));
      chk("wave",     32'(wave),     32'(m_wave));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (each is entered and left at a negedge)
  // ---------------------------------------------------------------------------
  task automatic write_entry(input int a, input int d, input int w);
    cfg_we    = 1'b1;
    cfg_addr  = IDX_W'(a);
    cfg_div   = DIV_W'(d);
    cfg_dwell = DWELL_W'(w);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int t0, o;
    reset = 1'b1; cfg_we = 0; cfg_addr = 0; cfg_div = 0; cfg_dwell = 0;
    start = 0; stop = 0; loop_en = 0;

    // Reset with random traffic on the inputs: outputs must stay at zero.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_out",  32'({done, tick, wave, step_idx}), 0);
      cfg_we    = 1'($urandom_range(0, 1));
      cfg_addr  = IDX_W'($urandom_range(0, N - 1));
      cfg_div   = DIV_W'($urandom_range(0, 20));
      cfg_dwell = DWELL_W'($urandom_range(0, 5));
      start     = 1'($urandom_range(0, 1));
      stop      = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    reset = 0; cfg_we = 0; start = 0; stop = 0;
    @(negedge clk);

    // Table: 0=(4,2), 1=(0,0) sanitised to (2,1), 2..7=(2,1).
    write_entry(0, 4, 2);
    write_entry(1, 0, 0);
    for (int a = 2; a < N; a++) write_entry(a, 2, 1);
    @(negedge clk);

    // Sweep 1, non-looping: ticks at T+5, T+9, then T+9+3k for step k.
    loop_en = 0;
    t0 = cyc;
    pulse_start();
    for (int k = 0; k < 33; k++) begin
      o = cyc - t0;
      if (o == 1)  chk("s1_busy_T+1", 32'(busy), 1);
      if (o == 4)  chk("s1_tick_T+4", 32'(tick), 0);
      if (o == 5)  chk("s1_tick_T+5", 32'(tick), 1);
      if (o == 6)  chk("s1_wave_T+6", 32'(wave), 1);
      if (o == 9)  chk("s1_tick_T+9", 32'(tick), 1);
      if (o == 10) chk("s1_load_T+10", 32'({busy, tick, step_idx}), 32'({1'b1, 1'b0, 3'd1}));
      if (o == 11) chk("s1_tick_T+11", 32'(tick), 0);
      if (o == 12) chk("s1_tick_T+12", 32'(tick), 1);
      if (o == 13) chk("s1_idx_T+13", 32'(step_idx), 2);
      if (o == 30) chk("s1_last_T+30", 32'({tick, step_idx}), 32'({1'b1, 3'd7}));
      if (o == 31) chk("s1_done_T+31", 32'({done, busy, wave}), 32'({1'b1, 1'b0, 1'b0}));
      if (o == 32) chk("s1_done_T+32", 32'(done), 0);
      @(negedge clk);
    end

    // Sweep 2, looping: wrap to entry 0, ignored busy write, stop on step end.
    loop_en = 1;
    t0 = cyc;
    pulse_start();
    for (int k = 0; k < 41; k++) begin
      o = cyc - t0;
      if (o == 31) chk("s2_wrap_T+31", 32'({busy, done, step_idx}), 32'({1'b1, 1'b0, 3'd0}));
      if (o == 35) chk("s2_tick_T+35", 32'(tick), 1);
      if (o == 39) chk("s2_tick_T+39", 32'(tick), 1);
      if (o == 40) chk("s2_stop_T+40", 32'({busy, done, wave, step_idx}), 0);
      if (o == 36) write_entry(0, 9, 5);
      else begin
        stop = (o == 39);
        @(negedge clk);
        stop = 1'b0;
      end
    end

    // start+stop together while idle: no sweep.
    loop_en = 0;
    start = 1; stop = 1;
    @(negedge clk);
    start = 0; stop = 0;
    chk("ss_idle", 32'(busy), 0);
    @(negedge clk);

    // Sweep 3: entry 0 still has divisor 4.
    t0 = cyc;
    pulse_start();
    for (int k = 0; k < 34; k++) begin
      o = cyc - t0;
      if (o == 4) chk("s3_tick_T+4", 32'(tick), 0);
      if (o == 5) chk("s3_tick_T+5", 32'(tick), 1);
      if (o == 31) chk("s3_done_T+31", 32'(done), 1);
      @(negedge clk);
    end

    // Randomised phase.
    for (int i = 0; i < 4000; i++) begin
      reset     = ($urandom_range(0, 299) == 0);
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_addr  = IDX_W'($urandom_range(0, N - 1));
      cfg_div   = DIV_W'($urandom_range(0, 6));
      cfg_dwell = DWELL_W'($urandom_range(0, 3));
      start     = ($urandom_range(0, 19) == 0);
      stop      = ($urandom_range(0, 59) == 0);
      loop_en   = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    reset = 0; cfg_we = 0; start = 0; stop = 0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
